// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
// freq_pkg : codes, FSM states and selection helper shared by freq_sel_ctrl/dcm
// Rev 1.0
// ============================================================================
package freq_pkg;

  localparam int PROG_W = 3;
  localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } fsm_state_e;

  // Slow-clock codes understood by dcm: each step halves the frequency.
  typedef enum logic [PROG_W-1:0] {
    FREQ_10HZ       = 3'd0,
    FREQ_5HZ        = 3'd1,
    FREQ_2HZ5       = 3'd2,
    FREQ_1HZ25      = 3'd3,
    FREQ_0HZ625     = 3'd4,
    FREQ_0HZ3125    = 3'd5,
    FREQ_0HZ15625   = 3'd6,
    FREQ_0HZ078125  = 3'd7
  } freq_code_e;

  function automatic logic [PROG_W-1:0] sel_step(
    input logic [PROG_W-1:0] cur,
    input logic              up,
    input logic              down
  );
    sel_step = cur;
    if (up && !down && (cur != PROG_MAX)) begin
      sel_step = cur + 3'd1;
    end else if (down && !up && (cur != '0)) begin
      sel_step = cur - 3'd1;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-FF synchroniser, level debouncer and press-pulse generator
// Rev 1.0
// ============================================================================
module btn_debounce
  import freq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      meta_q       <= btn_i;
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // High for the single cycle after the debounced level rises.
  assign press_o = stable_q & ~stable_dly_q;

endmodule
`default_nettype wire

// File: rtl/freq_sel_ctrl.sv
`default_nettype none
// ============================================================================
// freq_sel_ctrl : pushbutton frequency selector and apply handshake to dcm
// Rev 1.0
// ============================================================================
module freq_sel_ctrl
  import freq_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACK_TIMEOUT     = 1500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_apply,
  input  logic [PROG_W-1:0] prog_out,
  output logic [PROG_W-1:0] sel,
  output logic [PROG_W-1:0] prog_in,
  output logic              update,
  output logic              busy,
  output logic              err
);

  localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);

  logic up_evt;
  logic down_evt;
  logic apply_evt;

  fsm_state_e        state_q, state_d;
  logic [PROG_W-1:0] sel_q, sel_d;
  logic [PROG_W-1:0] prog_in_q, prog_in_d;
  logic              update_q, update_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [31:0]       to_cnt_q, to_cnt_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_up),
    .press_o (up_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_down),
    .press_o (down_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_apply (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_apply),
    .press_o (apply_evt)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_step(sel_q, up_evt, down_evt);
    prog_in_d = prog_in_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (apply_evt) begin
          state_d   = ST_PULSE;
          prog_in_d = sel_q;
          err_d     = 1'b0;
        end
      end
      ST_PULSE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // A match on the timeout cycle still counts as success.
        if (prog_out == prog_in_q) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    update_d = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= FREQ_10HZ;
      prog_in_q <= FREQ_10HZ;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      prog_in_q <= prog_in_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign sel     = sel_q;
  assign prog_in = prog_in_q;
  assign update  = update_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: doc/freq_sel_ctrl.md
Name: freq_sel_ctrl

Overview:
Upstream control stage for the dcm clock manager. It turns three raw pushbuttons (up, down, apply) into a debounced, saturating 3-bit slow-clock selection. On apply it issues the one-cycle `update` pulse with a stable `prog_in` to dcm. It then watches dcm's `prog_out` until the new frequency is confirmed, or a timeout expires.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a button level change (10 ms at 100 MHz); minimum 2.
ACK_TIMEOUT, 1500000000, clk cycles to wait in WAIT_ACK for prog_out == prog_in before flagging error (15 s covers the slowest clk_2 period of 12.8 s).

Ports:
clk  in  1  100 MHz system clock, same clock as dcm
rst  in  1  asynchronous, active-low reset (asserted at 0)
btn_up  in  1  raw pushbutton, asynchronous, active-high
btn_down  in  1  raw pushbutton, asynchronous, active-high
btn_apply  in  1  raw pushbutton, asynchronous, active-high
prog_out  in  3  frequency code currently generated by dcm
sel  out  3  pending selection, for display
prog_in  out  3  committed selection driven to dcm
update  out  1  one-cycle request to dcm
busy  out  1  high in PULSE and WAIT_ACK
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): sel=0, prog_in=0, update=0, busy=0, err=0, FSM=IDLE. All sync/debounce state is cleared to 0.
- Synchronisation: each button passes through a 2-FF synchroniser.
- Debounce, per button:
  - Keeps a stable level and a counter (width = clog2(DEBOUNCE_CYCLES)).
  - While the synced level equals stable, the counter is 0.
  - Otherwise the counter increments each cycle. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: one-cycle pulse on the cycle after stable goes 0->1. Release generates nothing.
- Selection (any FSM state):
  - up_evt alone: sel = min(sel+1, 7).
  - down_evt alone: sel = max(sel-1, 0).
  - up_evt and down_evt in the same cycle: sel unchanged.
  - Saturation: no wrap-around at 7 or 0.
- FSM states: IDLE, PULSE, WAIT_ACK.
  - IDLE:
    - apply_evt -> PULSE.
    - On the same edge: prog_in <= sel, err <= 0.
    - Other inputs: stay.
  - PULSE:
    - update=1 for exactly this one cycle.
    - prog_in is stable from this cycle until the next PULSE.
    - Timeout counter cleared.
    - Always -> WAIT_ACK.
  - WAIT_ACK:
    - If prog_out == prog_in -> IDLE.
    - Else if the timeout counter reaches ACK_TIMEOUT-1 -> IDLE and err <= 1.
    - Else the counter increments.
    - If match and timeout coincide, match wins and err stays 0.
- busy: registered, high exactly while FSM is PULSE or WAIT_ACK.
- apply_evt while busy: ignored, not queued.
- Apply with sel equal to the current prog_out: full PULSE is still issued; WAIT_ACK exits on its first cycle.
- Reset mid-operation: FSM returns to IDLE asynchronously and update drops immediately. No pulse is replayed after release.
- Width rule: the timeout counter is 32 bits unsigned.

Decomposition:
- Shared package freq_pkg:
  - Constant PROG_W=3 and PROG_MAX=3'd7.
  - FSM state enum (IDLE, PULSE, WAIT_ACK).
  - Frequency code constants shared with dcm (code 0 = 10 Hz, each step halves, code 7 = 78.125 mHz).
- One sub-module, btn_debounce: 2-FF sync, debounce counter, rising-edge press pulse. Instantiated three times with DEBOUNCE_CYCLES passed down.

Test Plan (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=20; a behavioural dcm model echoes prog_in to prog_out N cycles after update):
- Reset: hold rst=0 for 3 cycles, then release -> sel=0, prog_in=0, update=0, busy=0, err=0.
- Debounce: btn_up high for 3 cycles -> sel stays 0. btn_up high for 10 cycles -> sel=1 exactly once, and holding longer does not re-increment.
- Saturation: 9 up presses -> sel=7. 9 down presses -> sel=0. Up and down pressed in lockstep -> sel unchanged.
- Apply handshake: sel=5, press apply, model echoes after 6 cycles:
  - update high for exactly 1 cycle with prog_in=5.
  - busy high through the cycle prog_out becomes 5, then 0.
  - err=0.
- Timeout: model never echoes, press apply -> err=1 and busy=0 after 20 WAIT_ACK cycles. A second apply clears err on its PULSE entry.
- Busy/reset corner: press apply again while busy -> no second update pulse. Pull rst low during WAIT_ACK -> busy=0 and update=0 immediately, with no update after release.
